// File: rtl/sap_pkg.sv
// Shared types for the SAP control sequencer.
// SAP_JMP_EN adds the pc_ld strobe used by JMP.
package sap_pkg;

  typedef enum logic [3:0] {
    OP_LDA = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_JMP = 4'h6,
    OP_OUT = 4'he,
    OP_HLT = 4'hf
  } opcode_t;

  typedef enum logic [2:0] {
    S_PAUSE = 3'd0,
    S_T1    = 3'd1,
    S_T2    = 3'd2,
    S_T3    = 3'd3,
    S_T4    = 3'd4,
    S_T5    = 3'd5,
    S_T6    = 3'd6,
    S_HALT  = 3'd7
  } tstate_t;

  typedef struct packed {
    logic pc_en;
    logic ir_en;
    logic mem_en;
    logic a_en;
    logic adder_en;
    logic pc_inc;
    logic mar_ld;
    logic ir_ld;
    logic a_ld;
    logic b_ld;
    logic out_ld;
    logic sub;
`ifdef SAP_JMP_EN
    logic pc_ld;
`endif
    logic instr_done;
    logic halted;
  } ctrl_t;

endpackage

// File: rtl/sap_ring_counter.sv
// T-state register with run gating and HALT absorption.
// Async active-high reset returns to PAUSE.
module sap_ring_counter
  import sap_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    i_run,
  input  logic    i_hlt,
  output tstate_t o_state
);

  tstate_t r_state;
  tstate_t w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_PAUSE: w_next = i_run ? S_T1 : S_PAUSE;
      S_T1:    w_next = S_T2;
      S_T2:    w_next = S_T3;
      S_T3:    w_next = S_T4;
      S_T4:    w_next = i_hlt ? S_HALT : S_T5;
      S_T5:    w_next = S_T6;
      S_T6:    w_next = i_run ? S_T1 : S_PAUSE;
      S_HALT:  w_next = S_HALT;
      default: w_next = S_PAUSE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_PAUSE;
    else     r_state <= w_next;
  end

  assign o_state = r_state;

endmodule

// File: rtl/sap_controller.sv
// SAP control sequencer: T-state counter plus opcode decode.
// Define SAP_JMP_EN to add the JMP instruction and pc_ld port.
module sap_controller
  import sap_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [3:0] opcode,
  output logic       pc_en,
  output logic       ir_en,
  output logic       mem_en,
  output logic       a_en,
  output logic       adder_en,
  output logic       pc_inc,
  output logic       mar_ld,
  output logic       ir_ld,
  output logic       a_ld,
  output logic       b_ld,
  output logic       out_ld,
  output logic       sub,
`ifdef SAP_JMP_EN
  output logic       pc_ld,
`endif
  output logic       instr_done,
  output logic       halted
);

  tstate_t w_state;
  ctrl_t   w_c;
  logic    w_hlt;

  assign w_hlt = (opcode == OP_HLT);

  sap_ring_counter u_ring (
    .clk     (clk),
    .rst     (rst),
    .i_run   (run),
    .i_hlt   (w_hlt),
    .o_state (w_state)
  );

  always_comb begin
    w_c = '0;
    case (w_state)
      S_T1: begin
        w_c.pc_en  = 1'b1;
        w_c.mar_ld = 1'b1;
      end
      S_T2: w_c.pc_inc = 1'b1;
      S_T3: begin
        w_c.mem_en = 1'b1;
        w_c.ir_ld  = 1'b1;
      end
      S_T4: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: begin
            w_c.ir_en  = 1'b1;
            w_c.mar_ld = 1'b1;
          end
          OP_OUT: begin
            w_c.a_en   = 1'b1;
            w_c.out_ld = 1'b1;
          end
`ifdef SAP_JMP_EN
          OP_JMP: begin
            w_c.ir_en = 1'b1;
            w_c.pc_ld = 1'b1;
          end
`endif
          default: ;
        endcase
      end
      S_T5: begin
        case (opcode)
          OP_LDA: begin
            w_c.mem_en = 1'b1;
            w_c.a_ld   = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            w_c.mem_en = 1'b1;
            w_c.b_ld   = 1'b1;
          end
          default: ;
        endcase
      end
      S_T6: begin
        w_c.instr_done = 1'b1;
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          w_c.adder_en = 1'b1;
          w_c.a_ld     = 1'b1;
          w_c.sub      = (opcode == OP_SUB);
        end
      end
      S_HALT: w_c.halted = 1'b1;
      default: ;
    endcase
  end

  assign pc_en      = w_c.pc_en;
  assign ir_en      = w_c.ir_en;
  assign mem_en     = w_c.mem_en;
  assign a_en       = w_c.a_en;
  assign adder_en   = w_c.adder_en;
  assign pc_inc     = w_c.pc_inc;
  assign mar_ld     = w_c.mar_ld;
  assign ir_ld      = w_c.ir_ld;
  assign a_ld       = w_c.a_ld;
  assign b_ld       = w_c.b_ld;
  assign out_ld     = w_c.out_ld;
  assign sub        = w_c.sub;
`ifdef SAP_JMP_EN
  assign pc_ld      = w_c.pc_ld;
`endif
  assign instr_done = w_c.instr_done;
  assign halted     = w_c.halted;

endmodule

// File: tb/tb_sap_controller.sv
// Self-checking bench for sap_controller (default build or SAP_JMP_EN).
// Instruction-level model compared every negedge plus literal spot checks.
module tb_sap_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [3:0] opcode;
  logic pc_en, ir_en, mem_en, a_en, adder_en, pc_inc;
  logic mar_ld, ir_ld, a_ld, b_ld, out_ld, sub;
  logic instr_done, halted;
  logic pc_ld;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sap_controller dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .opcode     (opcode),
    .pc_en      (pc_en),
    .ir_en      (ir_en),
    .mem_en     (mem_en),
    .a_en       (a_en),
    .adder_en   (adder_en),
    .pc_inc     (pc_inc),
    .mar_ld     (mar_ld),
    .ir_ld      (ir_ld),
    .a_ld       (a_ld),
    .b_ld       (b_ld),
    .out_ld     (out_ld),
    .sub        (sub),
`ifdef SAP_JMP_EN
    .pc_ld      (pc_ld),
`endif
    .instr_done (instr_done),
    .halted     (halted)
  );

`ifndef SAP_JMP_EN
  assign pc_ld = 1'b0;
`endif

  logic [14:0] w_dut;
  assign w_dut = {pc_en, ir_en, mem_en, a_en, adder_en, pc_inc,
                  mar_ld, ir_ld, a_ld, b_ld, out_ld, sub,
                  pc_ld, instr_done, halted};

  // model position: 0 idle, 1..6 cycle within instruction, 7 halted
  int m_ph;

  always @(posedge clk or posedge rst) begin
    if (rst) m_ph <= 0;
    else if (m_ph == 0) m_ph <= run ? 1 : 0;
    else if (m_ph == 4 && opcode == 4'hf) m_ph <= 7;
    else if (m_ph == 6) m_ph <= run ? 1 : 0;
    else if (m_ph == 7) m_ph <= 7;
    else m_ph <= m_ph + 1;
  end

  function automatic logic [14:0] exp_vec(int ph, logic [3:0] op);
    logic pe, ie, me, ae, de, pi, ml, il, al, bl, ol, sb, pl, dn, hl;
    logic jmp_on;
    {pe, ie, me, ae, de, pi, ml, il, al, bl, ol, sb, pl, dn, hl} = '0;
`ifdef SAP_JMP_EN
    jmp_on = 1'b1;
`else
    jmp_on = 1'b0;
`endif
    if (ph == 1) begin pe = 1; ml = 1; end
    if (ph == 2) pi = 1;
    if (ph == 3) begin me = 1; il = 1; end
    if (ph == 4 && op <= 4'h2) begin ie = 1; ml = 1; end
    if (ph == 4 && op == 4'he) begin ae = 1; ol = 1; end
    if (ph == 4 && op == 4'h6 && jmp_on) begin ie = 1; pl = 1; end
    if (ph == 5 && op == 4'h0) begin me = 1; al = 1; end
    if (ph == 5 && (op == 4'h1 || op == 4'h2)) begin me = 1; bl = 1; end
    if (ph == 6) dn = 1;
    if (ph == 6 && (op == 4'h1 || op == 4'h2)) begin
      de = 1; al = 1; sb = (op == 4'h2);
    end
    if (ph == 7) hl = 1;
    return {pe, ie, me, ae, de, pi, ml, il, al, bl, ol, sb, pl, dn, hl};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("cycle_model", {17'd0, w_dut}, {17'd0, exp_vec(m_ph, opcode)});
    chk("bus_onehot",
        {31'd0, ($countones({pc_en, ir_en, mem_en, a_en, adder_en}) <= 1)},
        32'd1);
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // entered and left at T1 of an instruction with run held high
  task automatic do_instr(logic [3:0] op);
    opcode = op;
    tick(3);
    if (op == 4'he) chk("out_t4", {30'd0, a_en, out_ld}, 32'd3);
    tick(2);
    chk("t6_done", {31'd0, instr_done}, 32'd1);
    if (op == 4'h2) chk("sub_t6", {29'd0, adder_en, a_ld, sub}, 32'd7);
    tick(1);
    chk("t1_follow", {30'd0, pc_en, mar_ld}, 32'd3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int strobes;
    rst = 1'b1; run = 1'b0; opcode = 4'h1;
    #2;
    chk("reset_zero", {17'd0, w_dut}, 32'd0);
    #20;
    rst = 1'b0;
    run = 1'b1;
    tick(1);
    chk("start_t1", {30'd0, pc_en, mar_ld}, 32'd3);
    tick(4);
    chk("add_t5", {30'd0, mem_en, b_ld}, 32'd3);
    #2 rst = 1'b1;
    #1 chk("async_rst", {17'd0, w_dut}, 32'd0);
    run = 1'b0;
    #2 rst = 1'b0;
    strobes = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (w_dut != 0) strobes++;
    end
    chk("paused_quiet", strobes, 32'd0);
    run = 1'b1;
    tick(1);
    chk("rerun_t1", {30'd0, pc_en, mar_ld}, 32'd3);

    opcode = 4'h0;
    tick(3);
    chk("lda_t4", {30'd0, ir_en, mar_ld}, 32'd3);
    tick(1);
    chk("lda_t5", {30'd0, mem_en, a_ld}, 32'd3);
    tick(1);
    chk("lda_t6", {17'd0, w_dut}, 32'd2);
    tick(1);
    do_instr(4'h2);
    do_instr(4'h1);

    opcode = 4'h0;
    tick(2);
    run = 1'b0;
    tick(3);
    chk("drop_t6", {31'd0, instr_done}, 32'd1);
    tick(1);
    chk("drop_pause", {17'd0, w_dut}, 32'd0);
    run = 1'b1;
    tick(1);
    chk("resume_t1", {30'd0, pc_en, mar_ld}, 32'd3);

    do_instr(4'h6);
    for (int i = 0; i < 170; i++)
      do_instr(4'($urandom_range(0, 14)));

    do_instr(4'he);
    opcode = 4'hf;
    tick(3);
    chk("hlt_t4", {17'd0, w_dut}, 32'd0);
    tick(1);
    chk("hlt_halted", {31'd0, halted}, 32'd1);
    strobes = 0;
    for (int i = 0; i < 20; i++) begin
      run = 1'($urandom_range(0, 1));
      opcode = 4'($urandom_range(0, 15));
      tick(1);
      if (w_dut != 15'd1) strobes++;
    end
    chk("halt_frozen", strobes, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
